// File: rtl/ibex_mult_share_arbiter.sv
// Shares the fast multiplier between the multdiv path (core) and the neural control unit (neur).
// Grants one owner at a time, sequences its latency and bounds neural starvation.
module ibex_mult_share_arbiter #(
    parameter int unsigned CoreLatency = 2,
    parameter int unsigned NeurLatency = 1,
    parameter int unsigned StarveLimit = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       core_req_i,
    input  logic       core_flush_i,
    input  logic       neur_req_i,
    input  logic [1:0] neur_mode_i,
    output logic       core_gnt_o,
    output logic       neur_gnt_o,
    output logic       core_valid_o,
    output logic       neur_valid_o,
    output logic       neur_err_o,
    output logic       mul_en_o,
    output logic       mul_sel_neur_o,
    output logic [1:0] mul_mode_o,
    output logic       busy_o
);

    localparam int unsigned MaxLat = (CoreLatency > NeurLatency) ? CoreLatency : NeurLatency;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam int unsigned StW    = $clog2(StarveLimit + 1);

    localparam logic [CntW-1:0] CoreLoad = CntW'(CoreLatency - 1);
    localparam logic [CntW-1:0] NeurLoad = CntW'(NeurLatency - 1);
    localparam logic [StW-1:0]  StMax    = StW'(StarveLimit);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_CORE = 2'd1,
        RUN_NEUR = 2'd2
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [StW-1:0]  r_starve, w_starve_nxt;
    logic            r_sel_neur;
    logic [1:0]      r_mode;

    logic w_done;
    logic w_arb;
    logic w_neur_legal;
    logic w_core_gnt;
    logic w_neur_gnt;
    logic w_core_valid;
    logic w_neur_valid;
    logic w_err;

    assign w_done       = (r_cnt == '0);
    assign w_neur_legal = neur_req_i & (neur_mode_i != 2'b00);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_arb        = 1'b0;
        w_core_gnt   = 1'b0;
        w_neur_gnt   = 1'b0;
        w_core_valid = 1'b0;
        w_neur_valid = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
            end
            RUN_CORE: begin
                // A flush kills the op outright, even on its completion cycle.
                if (core_flush_i) begin
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_core_valid = 1'b1;
                    w_arb        = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            RUN_NEUR: begin
                if (w_done) begin
                    w_neur_valid = 1'b1;
                    w_arb        = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Grants are combinational, so hold them off while reset is asserted.
        if (w_arb && rst_ni) begin
            w_err = neur_req_i & (neur_mode_i == 2'b00);
            if (w_neur_legal && (!core_req_i || (r_starve == StMax))) begin
                w_neur_gnt  = 1'b1;
                w_state_nxt = RUN_NEUR;
                w_cnt_nxt   = NeurLoad;
            end else if (core_req_i) begin
                w_core_gnt  = 1'b1;
                w_state_nxt = RUN_CORE;
                w_cnt_nxt   = CoreLoad;
            end
        end
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (!neur_req_i || w_neur_gnt) begin
            w_starve_nxt = '0;
        end else if (r_starve != StMax) begin
            w_starve_nxt = r_starve + StW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Operand select and mode stay with the last owner until the next grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sel_neur <= 1'b0;
            r_mode     <= 2'b00;
        end else if (w_neur_gnt) begin
            r_sel_neur <= 1'b1;
            r_mode     <= neur_mode_i;
        end else if (w_core_gnt) begin
            r_sel_neur <= 1'b0;
            r_mode     <= 2'b00;
        end
    end

    assign core_gnt_o     = w_core_gnt;
    assign neur_gnt_o     = w_neur_gnt;
    assign core_valid_o   = w_core_valid;
    assign neur_valid_o   = w_neur_valid;
    assign neur_err_o     = w_err;
    assign mul_en_o       = w_core_gnt | w_neur_gnt;
    assign mul_sel_neur_o = r_sel_neur;
    assign mul_mode_o     = r_mode;
    assign busy_o         = (r_state != IDLE);

endmodule
